// File: rtl/conv_pkg.sv
// Shared types and the output saturation/ReLU helper for the conv_dyn datapath.
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Wide enough to carry any accumulator the MAC can be built with.
    localparam int SAT_W = 64;

    // Clamp v to the signed range of 'width' bits, then optionally zero negatives.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] v,
        input int                      width,
        input logic                    relu
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end else begin
            r = v;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate lane with clear/enable and a saturated T-bit output.
module conv_mac
    import conv_pkg::*;
#(
    parameter int T    = 8,
    parameter int M    = 4,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic signed [T-1:0] a_i,
    input  logic signed [T-1:0] b_i,
    output logic signed [T-1:0] y_o
);

    // M products of two T-bit values cannot overflow this width.
    localparam int AW = 2 * T + $clog2(M);

    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  acc_base;
    logic signed [2*T-1:0] prod;

    assign prod = (2*T)'(a_i) * (2*T)'(b_i);

    // Clear restarts the sum; a clear together with enable loads the first product.
    always_comb begin
        acc_base = clr_i ? '0 : acc_q;
        acc_d    = en_i ? (acc_base + AW'(prod)) : acc_base;
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign y_o = T'(sat_relu(SAT_W'(acc_q), T, RELU != 0));

endmodule

// File: rtl/conv_dyn.sv
// Streaming 1-D valid convolution: load x and f, compute P outputs per group, drain.
module conv_dyn
    import conv_pkg::*;
#(
    parameter int N    = 16,
    parameter int M    = 4,
    parameter int T    = 8,
    parameter int P    = 1,
    parameter int RELU = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in_x,
    input  logic                s_valid_x,
    output logic                s_ready_x,
    input  logic signed [T-1:0] s_data_in_f,
    input  logic                s_valid_f,
    output logic                s_ready_f,
    output logic signed [T-1:0] m_data_out_y,
    output logic                m_valid_y,
    input  logic                m_ready_y
);

    localparam int CW      = $clog2(N + 1);
    localparam int IW      = $clog2(N);
    localparam int FW      = $clog2(M);
    localparam int DW      = (P > 1) ? $clog2(P) : 1;
    localparam int LAST_K0 = N - M + 1 - P;

    state_t              state_q;
    logic [CW-1:0]       x_cnt_q;
    logic [CW-1:0]       x_cnt_d;
    logic [CW-1:0]       f_cnt_q;
    logic [CW-1:0]       f_cnt_d;
    logic [CW-1:0]       k0_q;
    logic [FW-1:0]       j_q;
    logic [DW-1:0]       d_q;
    logic signed [T-1:0] x_q [N];
    logic signed [T-1:0] f_q [M];
    logic signed [T-1:0] lane_y [P];
    logic                x_hs;
    logic                f_hs;
    logic                y_hs;
    logic                mac_en;
    logic                mac_clr;

    // Handshake flags are decoded from registered state and gated by reset so the
    // ports are quiet during reset and open in the very first cycle after it.
    assign s_ready_x = !reset && (state_q == LOAD) && (x_cnt_q < CW'(N));
    assign s_ready_f = !reset && (state_q == LOAD) && (f_cnt_q < CW'(M));
    assign m_valid_y = !reset && (state_q == DRAIN);

    assign x_hs    = s_valid_x && s_ready_x;
    assign f_hs    = s_valid_f && s_ready_f;
    assign y_hs    = m_valid_y && m_ready_y;
    assign x_cnt_d = x_cnt_q + CW'(x_hs);
    assign f_cnt_d = f_cnt_q + CW'(f_hs);

    assign mac_en  = (state_q == COMPUTE);
    assign mac_clr = mac_en && (j_q == '0);

    // Operand storage, filled in arrival order; contents are overwritten every vector.
    always_ff @(posedge clk) begin
        if (x_hs) begin
            x_q[x_cnt_q[IW-1:0]] <= s_data_in_x;
        end
        if (f_hs) begin
            f_q[f_cnt_q[FW-1:0]] <= s_data_in_f;
        end
    end

    // Control FSM: load counters, accumulate tap index, group base and drain index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            x_cnt_q <= '0;
            f_cnt_q <= '0;
            k0_q    <= '0;
            j_q     <= '0;
            d_q     <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    x_cnt_q <= x_cnt_d;
                    f_cnt_q <= f_cnt_d;
                    // Look at the post-handshake counts so a final x and f arriving
                    // together still move us on this edge.
                    if ((x_cnt_d == CW'(N)) && (f_cnt_d == CW'(M))) begin
                        state_q <= COMPUTE;
                        k0_q    <= '0;
                        j_q     <= '0;
                    end
                end
                COMPUTE: begin
                    if (j_q == FW'(M - 1)) begin
                        state_q <= DRAIN;
                        j_q     <= '0;
                        d_q     <= '0;
                    end else begin
                        j_q <= j_q + FW'(1);
                    end
                end
                DRAIN: begin
                    if (y_hs) begin
                        if (d_q != DW'(P - 1)) begin
                            d_q <= d_q + DW'(1);
                        end else if (k0_q == CW'(LAST_K0)) begin
                            state_q <= LOAD;
                            x_cnt_q <= '0;
                            f_cnt_q <= '0;
                        end else begin
                            state_q <= COMPUTE;
                            k0_q    <= k0_q + CW'(P);
                            d_q     <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    // One MAC per lane; lane g of the group computes output k0+g.
    for (genvar g = 0; g < P; g++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx = IW'(k0_q) + IW'(g) + IW'(j_q);
        conv_mac #(
            .T    (T),
            .M    (M),
            .RELU (RELU)
        ) u_mac (
            .clk   (clk),
            .reset (reset),
            .clr_i (mac_clr),
            .en_i  (mac_en),
            .a_i   (x_q[idx]),
            .b_i   (f_q[j_q]),
            .y_o   (lane_y[g])
        );
    end

    // Present the lane selected by the drain index; stable until its handshake.
    always_comb begin
        m_data_out_y = lane_y[0];
        for (int p = 1; p < P; p++) begin
            if (d_q == DW'(p)) begin
                m_data_out_y = lane_y[p];
            end
        end
    end

endmodule

// File: tb/tb_conv_dyn.sv
// Self-checking bench for conv_dyn: directed and randomized vectors against a
// behavioural convolution model.
module tb_conv_dyn;

    localparam int N    = 16;
    localparam int M    = 4;
    localparam int T    = 8;
    localparam int NOUT = N - M + 1;
    localparam int YMAX = (1 << (T - 1)) - 1;
    localparam int YMIN = -(1 << (T - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int                  sel;
    logic signed [T-1:0] dx;
    logic signed [T-1:0] df;
    logic                vx;
    logic                vf;
    logic                ry;

    logic a_sel;
    logic b_sel;
    assign a_sel = (sel == 0);
    assign b_sel = (sel == 1);

    logic a_rx, a_rf, a_vy, b_rx, b_rf, b_vy, c_rx, c_rf, c_vy;
    logic signed [T-1:0] a_y, b_y, c_y;

    conv_dyn #(.N(N), .M(M), .T(T), .P(1), .RELU(0)) u_a (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx), .s_valid_x(vx & a_sel), .s_ready_x(a_rx),
        .s_data_in_f(df), .s_valid_f(vf & a_sel), .s_ready_f(a_rf),
        .m_data_out_y(a_y), .m_valid_y(a_vy), .m_ready_y(ry & a_sel));

    conv_dyn #(.N(N), .M(M), .T(T), .P(1), .RELU(1)) u_c (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx), .s_valid_x(vx & a_sel), .s_ready_x(c_rx),
        .s_data_in_f(df), .s_valid_f(vf & a_sel), .s_ready_f(c_rf),
        .m_data_out_y(c_y), .m_valid_y(c_vy), .m_ready_y(ry & a_sel));

    conv_dyn #(.N(N), .M(M), .T(T), .P(13), .RELU(0)) u_b (
        .clk(clk), .reset(reset),
        .s_data_in_x(dx), .s_valid_x(vx & b_sel), .s_ready_x(b_rx),
        .s_data_in_f(df), .s_valid_f(vf & b_sel), .s_ready_f(b_rf),
        .m_data_out_y(b_y), .m_valid_y(b_vy), .m_ready_y(ry & b_sel));

    logic                rx, rf, vy;
    logic signed [T-1:0] yo;
    assign rx = b_sel ? b_rx : a_rx;
    assign rf = b_sel ? b_rf : a_rf;
    assign vy = b_sel ? b_vy : a_vy;
    assign yo = b_sel ? b_y  : a_y;

    logic signed [T-1:0] xs [N];
    logic signed [T-1:0] fs [M];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: full-precision dot product, clamp to T bits, optional ReLU.
    function automatic int ref_y(input int k, input bit relu);
        int s;
        s = 0;
        for (int j = 0; j < M; j++) s += int'(xs[k + j]) * int'(fs[j]);
        if (s > YMAX) s = YMAX;
        if (s < YMIN) s = YMIN;
        if (relu && s < 0) s = 0;
        return s;
    endfunction

    task automatic fill_rand();
        logic [31:0] r;
        for (int i = 0; i < N; i++) begin r = $urandom; xs[i] = r[T-1:0]; end
        for (int i = 0; i < M; i++) begin r = $urandom; fs[i] = r[T-1:0]; end
    endtask

    // Drive one vector and collect outputs until stop_at words have been accepted.
    task automatic run_vec(input bit rnd, input bit skew, input bit stall, input int stop_at);
        int xi = 0, fi = 0, yi = 0, cyc = 0;
        int c_last = -1, first_vy = -1, x_done = -1, stall_left = 0;
        bit stalled = 0;
        logic signed [T-1:0] held = '0;
        while (yi < stop_at && cyc < 3000) begin
            @(negedge clk);
            vx = (xi < N) && (!rnd || ($urandom_range(0, 3) != 0));
            dx = xs[(xi < N) ? xi : 0];
            vf = (fi < M) && (!rnd || ($urandom_range(0, 3) != 0))
                 && (!skew || (x_done >= 0 && cyc >= x_done + 30));
            df = fs[(fi < M) ? fi : 0];
            if (stall && !stalled && yi == 3 && vy) begin
                stall_left = 20;
                stalled    = 1;
                held       = yo;
            end
            ry = (stall_left > 0) ? 1'b0 : (!rnd || ($urandom_range(0, 1) == 1));
            #1;
            if (vy && first_vy < 0) first_vy = cyc;
            if (stall_left > 0) begin
                chk("stall_valid", vy, 1);
                chk("stall_data", yo, held);
                stall_left--;
            end
            if (vx && rx) begin
                xi++;
                c_last = cyc;
                if (xi == N) x_done = cyc;
            end
            if (vf && rf) begin
                fi++;
                c_last = cyc;
            end
            if (vy && ry) begin
                chk($sformatf("y[%0d]", yi), yo, ref_y(yi, 0));
                if (sel == 0) chk($sformatf("relu_y[%0d]", yi), c_y, ref_y(yi, 1));
                yi++;
            end
            cyc++;
        end
        chk("words_out", yi, stop_at);
        if (stop_at == NOUT) begin
            chk("no_valid_during_load", int'(first_vy > c_last), 1);
            chk("first_valid_latency", int'(first_vy <= c_last + 1 + M + 2), 1);
            @(negedge clk);
            vx = 1'b0; vf = 1'b0; ry = 1'b0;
            #1;
            chk("ready_x_after_vec", rx, 1);
            chk("ready_f_after_vec", rf, 1);
            chk("valid_after_vec", vy, 0);
        end
    endtask

    initial begin
        sel = 0; vx = 1'b0; vf = 1'b0; ry = 1'b0; dx = '0; df = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready_x", rx, 0);
        chk("rst_ready_f", rf, 0);
        chk("rst_valid_y", vy, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready_x", rx, 1);
        chk("post_rst_ready_f", rf, 1);
        chk("post_rst_valid_y", vy, 0);

        // Basic ramp with a unit box filter: 10, 14, ..., 58.
        for (int i = 0; i < N; i++) xs[i] = T'(i + 1);
        for (int i = 0; i < M; i++) fs[i] = T'(1);
        chk("basic_model_first", ref_y(0, 0), 10);
        chk("basic_model_last", ref_y(NOUT - 1, 0), 58);
        run_vec(0, 0, 0, NOUT);

        // Positive and negative saturation (ReLU instance sees the same stimulus).
        for (int i = 0; i < N; i++) xs[i] = 8'sd127;
        for (int i = 0; i < M; i++) fs[i] = 8'sd127;
        run_vec(0, 0, 0, NOUT);
        for (int i = 0; i < M; i++) fs[i] = -8'sd128;
        run_vec(0, 0, 0, NOUT);

        // Backpressure mid-drain.
        fill_rand();
        run_vec(1, 0, 1, NOUT);

        // Filter words arrive 30 cycles after the last x word.
        fill_rand();
        run_vec(0, 1, 0, NOUT);

        // Reset after y[5], then a fresh vector must start from its own y[0].
        fill_rand();
        run_vec(1, 0, 0, 6);
        @(negedge clk);
        reset = 1'b1; vx = 1'b0; vf = 1'b0; ry = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_valid_y", vy, 0);
        chk("mid_rst_ready_x", rx, 0);
        reset = 1'b0;
        #1;
        chk("mid_post_rst_ready_x", rx, 1);
        fill_rand();
        run_vec(1, 0, 0, NOUT);

        // Randomized vectors on the single-lane and 13-lane builds.
        for (int v = 0; v < 300; v++) begin
            fill_rand();
            run_vec(1, 0, 0, NOUT);
        end
        sel = 1;
        for (int v = 0; v < 325; v++) begin
            fill_rand();
            run_vec(1, 0, 0, NOUT);
        end
        fill_rand();
        run_vec(1, 0, 1, NOUT);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
